sram_bist: RTL

//  Built-in self-test traffic source sitting directly upstream of sram_ctrl, clocked from the PLL clk_50m domain.

---
 rtl/sram_bist_pkg.sv | 26 ++
 rtl/sram_bist_cmp.sv | 49 ++++
 rtl/sram_bist.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sram_bist_pkg.sv
// sram_bist shared definitions: state codes, test pattern,
// default request timing (also used by the sram_ctrl bench).
package sram_bist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WR      = 3'd1;
  localparam state_t S_WR_WAIT = 3'd2;
  localparam state_t S_RD      = 3'd3;
  localparam state_t S_RD_WAIT = 3'd4;
  localparam state_t S_FAIL    = 3'd5;

  localparam int unsigned WR_GAP_DEF = 4;
  localparam int unsigned RD_LAT_DEF = 3;
  localparam int unsigned RD_GAP_DEF = 5;

  // Odd passes write the complement of even passes.
  function automatic logic [7:0] sram_bist_exp(
    input logic [14:0] addr,
    input logic        p
  );
    return addr[7:0] ^ {1'b0, addr[14:8]} ^ {8{p}};
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist read-back checker: tracks the outstanding read and
// flags a mismatch in the cycle its data is valid.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rreq,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rexp,
  input  logic [DATA_W-1:0] rdata,
  output logic              mismatch,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;

  assign mismatch = vld[RD_LAT-1] && (rdata != exp_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld       <= '0;
      addr_q    <= '0;
      exp_q     <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      vld[0] <= rreq;
      for (int i = 1; i < RD_LAT; i++)
        vld[i] <= vld[i-1];
      if (rreq) begin
        addr_q <= raddr;
        exp_q  <= rexp;
      end
      if (mismatch) begin
        fail_addr <= addr_q;
        fail_data <= rdata;
      end
    end
  end

endmodule

// File: rtl/sram_bist.sv
// sram_bist: write/read-back march over the SRAM, repeated
// pass after pass until stopped or until the first mismatch.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_LAST = 32767,
  parameter int unsigned WR_GAP    = WR_GAP_DEF,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int unsigned RD_GAP    = RD_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              sram_wreq,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_rreq,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              led,
  output logic              busy,
  output logic              fail,
  output logic [15:0]       pass_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ADDR_LAST);
  localparam logic [7:0] WR_END = 8'(WR_GAP - 2);
  localparam logic [7:0] RD_END = 8'(RD_GAP - 2);

  state_t state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [7:0] cnt, cnt_d;
  logic pass_done, mismatch;
  logic [15:0] pcnt_d;
  logic wreq_q, rreq_q, wreq_d, rreq_d;
  logic [DATA_W-1:0] wdata_d, rexp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      addr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    addr_d    = addr;
    cnt_d     = cnt;
    pass_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) begin
          state_d = S_WR;
          addr_d  = '0;
        end
      end
      S_WR: begin
        state_d = S_WR_WAIT;
        cnt_d   = '0;
      end
      S_WR_WAIT: begin
        if (cnt == WR_END) begin
          cnt_d = '0;
          if (addr < LAST) begin
            addr_d  = addr + ADDR_W'(1);
            state_d = S_WR;
          end else begin
            addr_d  = '0;
            state_d = S_RD;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_RD: begin
        state_d = S_RD_WAIT;
        cnt_d   = '0;
      end
      S_RD_WAIT: begin
        if (mismatch) begin
          state_d = S_FAIL;
        end else if (cnt == RD_END) begin
          cnt_d = '0;
          if (addr < LAST) begin
            addr_d  = addr + ADDR_W'(1);
            state_d = S_RD;
          end else begin
            addr_d    = '0;
            pass_done = 1'b1;
            state_d   = run ? S_WR : S_IDLE;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  // Write data of a new pass must already use the bumped count.
  always_comb begin
    pcnt_d  = pass_cnt + 16'(pass_done);
    wreq_d  = (state_d == S_WR);
    rreq_d  = (state_d == S_RD);
    wdata_d = DATA_W'(sram_bist_exp(15'(addr_d), pcnt_d[0]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wreq_q     <= 1'b0;
      rreq_q     <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      sram_raddr <= '0;
      pass_cnt   <= '0;
      led        <= 1'b0;
      fail       <= 1'b0;
    end else begin
      wreq_q   <= wreq_d;
      rreq_q   <= rreq_d;
      pass_cnt <= pcnt_d;
      if (wreq_d) begin
        sram_waddr <= addr_d;
        sram_wdata <= wdata_d;
      end
      if (rreq_d)
        sram_raddr <= addr_d;
      if (state_d == S_FAIL) begin
        led  <= 1'b0;
        fail <= 1'b1;
      end else if (pass_done) begin
        led <= ~led;
      end
    end
  end

  // Requests are suppressed in any cycle reset is held.
  assign sram_wreq = wreq_q & rst;
  assign sram_rreq = rreq_q & rst;
  assign busy = (state != S_IDLE) && (state != S_FAIL);
  assign rexp = DATA_W'(sram_bist_exp(15'(sram_raddr), pass_cnt[0]));

  sram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .rreq      (rreq_q),
    .raddr     (sram_raddr),
    .rexp      (rexp),
    .rdata     (sram_rdata),
    .mismatch  (mismatch),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

endmodule
